pll_cfg_seq: RTL



---
 rtl/pll_cfg_pkg.sv | 81 ++++++++
 rtl/pll_cfg_if.sv | 30 +++
 rtl/pll_cfg_avmm_xfer.sv | 27 ++
 rtl/pll_cfg_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared constants, types and preset ROM for the PLL
// reconfiguration sequencer (register map, counter fields, states).
package pll_cfg_pkg;

    localparam logic [5:0] REG_MODE   = 6'd0;
    localparam logic [5:0] REG_STATUS = 6'd1;
    localparam logic [5:0] REG_START  = 6'd2;
    localparam logic [5:0] REG_N      = 6'd3;
    localparam logic [5:0] REG_M      = 6'd4;
    localparam logic [5:0] REG_C      = 6'd5;

    localparam int CNT_LO_LSB  = 0;
    localparam int CNT_HI_LSB  = 8;
    localparam int CNT_BYP_BIT = 16;
    localparam int CNT_ODD_BIT = 17;
    localparam int C_IDX_LSB   = 18;

    localparam logic [9:0] POLL_LAST = 10'd1023;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_WR_MODE   = 4'd1;
    localparam state_t ST_WR_M      = 4'd2;
    localparam state_t ST_WR_N      = 4'd3;
    localparam state_t ST_WR_C      = 4'd4;
    localparam state_t ST_WR_START  = 4'd5;
    localparam state_t ST_RD_STAT   = 4'd6;
    localparam state_t ST_WAIT_LOCK = 4'd7;
    localparam state_t ST_OK        = 4'd8;
    localparam state_t ST_FAIL      = 4'd9;

    typedef struct packed {
        logic [7:0] m_hi;
        logic [7:0] m_lo;
        logic [7:0] n_hi;
        logic [7:0] n_lo;
        logic       n_odd;
        logic [7:0] c_hi;
        logic [7:0] c_lo;
        logic       c_odd;
    } preset_t;

    localparam int PRESET_CNT = 4;

    // 0: 21 MHz, 1: 30 MHz, 2: 35 MHz, 3: 5 MHz; shared M and N
    localparam preset_t PRESET_ROM [PRESET_CNT] = '{
        '{8'd21, 8'd21, 8'd3, 8'd2, 1'b1, 8'd10, 8'd10, 1'b0},
        '{8'd21, 8'd21, 8'd3, 8'd2, 1'b1, 8'd7,  8'd7,  1'b0},
        '{8'd21, 8'd21, 8'd3, 8'd2, 1'b1, 8'd6,  8'd6,  1'b0},
        '{8'd21, 8'd21, 8'd3, 8'd2, 1'b1, 8'd42, 8'd42, 1'b0}
    };

    function automatic logic [31:0] cnt_word(
        input logic [7:0] hi,
        input logic [7:0] lo,
        input logic       odd
    );
        logic [31:0] w;
        w                   = '0;
        w[CNT_LO_LSB +: 8]  = lo;
        w[CNT_HI_LSB +: 8]  = hi;
        w[CNT_BYP_BIT]      = 1'b0;
        w[CNT_ODD_BIT]      = odd;
        return w;
    endfunction

    function automatic preset_t preset_at(input int unsigned idx);
        logic [1:0] sel;
        sel = idx[1:0];
        return (idx < PRESET_CNT) ? PRESET_ROM[sel] : PRESET_ROM[0];
    endfunction

    function automatic logic preset_in_range(
        input int unsigned idx,
        input int unsigned n
    );
        return idx < n;
    endfunction

endpackage

// File: rtl/pll_cfg_if.sv
// pll_cfg_if: Avalon-MM management bus toward altera_pll_reconfig.
// master = sequencer side, slave = reconfig block side.
interface pll_cfg_if;

    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_read,
        output mgmt_writedata,
        input  mgmt_readdata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_read,
        input  mgmt_writedata,
        output mgmt_readdata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/pll_cfg_avmm_xfer.sv
// pll_cfg_avmm_xfer: single-transfer Avalon-MM master.
// Ports: rst_n, go/rd/addr/wdata request, ack/rdata result, bus (master).
module pll_cfg_avmm_xfer (
    input  logic        rst_n,
    input  logic        go,
    input  logic        rd,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    pll_cfg_if.master   bus
);

    // Request is held by the caller's state until ack; rst_n gating
    // drops the strobes in the reset cycle itself.
    logic live;
    assign live = go && rst_n;

    assign bus.mgmt_write     = live && !rd;
    assign bus.mgmt_read      = live && rd;
    assign bus.mgmt_address   = live ? addr : '0;
    assign bus.mgmt_writedata = (live && !rd) ? wdata : '0;

    assign ack   = live && !bus.mgmt_waitrequest;
    assign rdata = bus.mgmt_readdata;

endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: programs a preset (M, N, C) into the PLL reconfig block,
// starts it, polls status and qualifies lock. Ports: clk, rst_n, req,
// req_preset, busy, done, err, cur_preset, pll_locked, mgmt (Avalon).
// Option: PLL_CFG_SKIP_SAME_EN skips re-applying the current preset.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int NUM_PRESETS  = 4,
    parameter int C_INDEX      = 1,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic [$clog2(NUM_PRESETS)-1:0] req_preset,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(NUM_PRESETS)-1:0] cur_preset,
    input  logic                           pll_locked,
    pll_cfg_if.master                      mgmt
);

    localparam int PW = $clog2(NUM_PRESETS);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(LOCK_TIMEOUT);

    state_t        state_q;
    logic [PW-1:0] preset_q;
    logic [PW-1:0] cur_q;
    logic [SW-1:0] stab_q;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_nxt;
    logic [9:0]    poll_q;
    logic          bad_q;
    logic          skip_q;

    logic          go;
    logic          rd;
    logic [5:0]    addr;
    logic [31:0]   wdata;
    logic          ack;
    logic [31:0]   rdata;
    logic          unused_rdata;
    preset_t       cfg;

    logic          idle_req;
    logic          pre_ok;
    logic          same_req;

    // Requests are refused while an IDLE-side done/err pulse is shown.
    assign idle_req = req && (state_q == ST_IDLE) && !bad_q && !skip_q;
    assign pre_ok   = preset_in_range(32'(req_preset), 32'(NUM_PRESETS));

`ifdef PLL_CFG_SKIP_SAME_EN
    logic applied_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            applied_q <= 1'b0;
        end else if (state_q == ST_OK) begin
            applied_q <= 1'b1;
        end
    end

    assign same_req = applied_q && (req_preset == cur_q);
`else
    assign same_req = 1'b0;
`endif

    assign tmo_nxt = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_OK) || skip_q;
    assign err        = (state_q == ST_FAIL) || bad_q;
    assign cur_preset = cur_q;

    assign cfg          = preset_at(32'(preset_q));
    assign unused_rdata = ^rdata[31:1];

    always_comb begin
        go    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        wdata = '0;
        case (state_q)
            ST_WR_MODE: begin
                go    = 1'b1;
                addr  = REG_MODE;
                wdata = 32'd1;
            end
            ST_WR_M: begin
                go    = 1'b1;
                addr  = REG_M;
                wdata = cnt_word(cfg.m_hi, cfg.m_lo, 1'b0);
            end
            ST_WR_N: begin
                go    = 1'b1;
                addr  = REG_N;
                wdata = cnt_word(cfg.n_hi, cfg.n_lo, cfg.n_odd);
            end
            ST_WR_C: begin
                go    = 1'b1;
                addr  = REG_C;
                wdata = cnt_word(cfg.c_hi, cfg.c_lo, cfg.c_odd);
                wdata[C_IDX_LSB +: 5] = 5'(C_INDEX);
            end
            ST_WR_START: begin
                go    = 1'b1;
                addr  = REG_START;
            end
            ST_RD_STAT: begin
                go    = 1'b1;
                rd    = 1'b1;
                addr  = REG_STATUS;
            end
            default: ;
        endcase
    end

    pll_cfg_avmm_xfer u_xfer (
        .rst_n (rst_n),
        .go    (go),
        .rd    (rd),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .bus   (mgmt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            preset_q <= '0;
            cur_q    <= '0;
            stab_q   <= '0;
            tmo_q    <= '0;
            poll_q   <= '0;
            bad_q    <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            bad_q  <= idle_req && !pre_ok;
            skip_q <= idle_req && pre_ok && same_req;
            case (state_q)
                ST_IDLE: begin
                    if (idle_req && pre_ok && !same_req) begin
                        preset_q <= req_preset;
                        stab_q   <= '0;
                        tmo_q    <= '0;
                        poll_q   <= '0;
                        state_q  <= ST_WR_MODE;
                    end
                end
                ST_WR_MODE:  if (ack) state_q <= ST_WR_M;
                ST_WR_M:     if (ack) state_q <= ST_WR_N;
                ST_WR_N:     if (ack) state_q <= ST_WR_C;
                ST_WR_C:     if (ack) state_q <= ST_WR_START;
                ST_WR_START: if (ack) state_q <= ST_RD_STAT;
                ST_RD_STAT: begin
                    if (ack) begin
                        if (rdata[0]) begin
                            state_q <= ST_WAIT_LOCK;
                        end else if (poll_q == POLL_LAST) begin
                            state_q <= ST_FAIL;
                        end else begin
                            poll_q <= poll_q + 10'd1;
                        end
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_q  <= tmo_nxt;
                    stab_q <= pll_locked ? stab_q + SW'(1) : '0;
                    // cur_preset moves with the done pulse
                    if (pll_locked && stab_q == STAB_LAST) begin
                        state_q <= ST_OK;
                        cur_q   <= preset_q;
                    end else if (tmo_nxt == TMO_MAX) begin
                        state_q <= ST_FAIL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
